// File: rtl/math_div_35.sv
// Radix-2 restoring divider: full 42x35 product-width dividend by a 35-bit divisor,
// one quotient bit per enabled cycle, valid/ready on both sides.
module math_div_35 #(
  parameter int A_WIDTH = 42,
  parameter int B_WIDTH = 35
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH+B_WIDTH-1:0] dividend,
  input  logic [B_WIDTH-1:0]         divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH-1:0]         quot,
  output logic [B_WIDTH-1:0]         rem,
  output logic                       err
);

  localparam int D_WIDTH = A_WIDTH + B_WIDTH;
  localparam int CNT_W   = $clog2(A_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [B_WIDTH-1:0]   part_q, part_d;
  logic [B_WIDTH-1:0]   dvs_q, dvs_d;
  logic [A_WIDTH-1:0]   shq_q, shq_d;
  logic [A_WIDTH-1:0]   quot_q, quot_d;
  logic [B_WIDTH-1:0]   rem_q, rem_d;
  logic                 err_q, err_d;

  logic                 accept, release_out, step, in_err;
  logic [B_WIDTH-1:0]   div_hi;
  logic [B_WIDTH:0]     trial, diff;
  logic                 qbit;
  logic [B_WIDTH-1:0]   part_next;
  logic [A_WIDTH-1:0]   shq_next;

  assign accept      = ena && in_valid && (state_q == S_IDLE);
  assign release_out = ena && out_ready && (state_q == S_DONE);
  assign step        = ena && (state_q == S_CALC);

  assign div_hi = dividend[D_WIDTH-1:A_WIDTH];
  assign in_err = (divisor == '0) || (div_hi >= divisor);

  // R < divisor holds throughout, so the trial value is below 2*divisor and the
  // borrow of the subtraction alone decides the quotient bit.
  assign trial     = {part_q, shq_q[A_WIDTH-1]};
  assign diff      = trial - {1'b0, dvs_q};
  assign qbit      = ~diff[B_WIDTH];
  assign part_next = qbit ? diff[B_WIDTH-1:0] : trial[B_WIDTH-1:0];
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  assign shq_next  = {shq_q[A_WIDTH-2:0], qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = in_err ? S_DONE : S_CALC;
      S_CALC: if (step && (cnt_q == '0)) state_d = S_DONE;
      S_DONE: if (release_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    dvs_d  = dvs_q;
    shq_d  = shq_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    err_d  = err_q;
    if (accept) begin
      dvs_d  = divisor;
      shq_d  = dividend[A_WIDTH-1:0];
      part_d = div_hi;
      cnt_d  = CNT_LAST;
      if (in_err) begin
        quot_d = '1;
        rem_d  = '0;
        err_d  = 1'b1;
      end else begin
        err_d  = 1'b0;
      end
    end
    if (step) begin
      part_d = part_next;
      shq_d  = shq_next;
      if (cnt_q == '0) begin
        quot_d = shq_next;
        rem_d  = part_next;
        err_d  = 1'b0;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      part_q <= '0;
      dvs_q  <= '0;
      shq_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
      dvs_q  <= dvs_d;
      shq_q  <= shq_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      err_q  <= err_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign err  = err_q;

endmodule

// File: tb/tb_math_div_35.sv
// Testbench for math_div_35: directed scenarios plus randomized traffic against
// an arithmetic reference model.
module tb_math_div_35;

  localparam int AW = 42;
  localparam int BW = 35;
  localparam int DW = AW + BW;
  localparam int N_RAND = 600;

  logic          clk = 1'b0;
  logic          rst_n, ena, in_valid, in_ready, out_valid, out_ready, err;
  logic [DW-1:0] dividend;
  logic [BW-1:0] divisor;
  logic [AW-1:0] quot;
  logic [BW-1:0] rem;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [AW-1:0] QMAX = '1;

  typedef struct {
    logic [DW-1:0] a;
    logic [BW-1:0] b;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  math_div_35 #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .err       (err)
  );

  function automatic void ref_div(input logic [DW-1:0] a, input logic [BW-1:0] b,
                                  output logic [AW-1:0] q, output logic [BW-1:0] r,
                                  output logic e);
    logic [DW-1:0] qf, rf;
    q = '1;
    r = '0;
    e = 1'b1;
    if (b != '0) begin
      qf = a / DW'(b);
      rf = a % DW'(b);
      if (qf < (DW'(1) << AW)) begin
        q = qf[AW-1:0];
        r = rf[BW-1:0];
        e = 1'b0;
      end
    end
  endfunction

  function automatic void gen_ops(output logic [DW-1:0] a, output logic [BW-1:0] b);
    logic [63:0]   w;
    logic [BW-1:0] hi;
    logic [AW-1:0] lo;
    int            sel;
    sel = $urandom_range(0, 31);
    w   = {$urandom, $urandom};
    b   = BW'(w >> $urandom_range(0, 34));
    if (sel == 0) b = '0;
    if (sel == 1) b = BW'(1);
    w  = {$urandom, $urandom};
    hi = BW'(w);
    if (sel >= 3 && b != '0) hi = hi % b;
    w  = {$urandom, $urandom};
    lo = AW'(w);
    a  = {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [DW-1:0] a, input logic [BW-1:0] b);
    logic [DW-1:0] ja;
    logic [BW-1:0] jb;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    gen_ops(ja, jb);
    dividend = ja;
    divisor  = jb;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({in_ready, out_valid, err, quot, rem} !== {1'b1, 1'b0, 1'b0, AW'(0), BW'(0)}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b err=%b q=%h r=%h exp rdy=1 vld=0 err=0 q=0 r=0",
               in_ready, out_valid, err, quot, rem);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, busy_rdy;
    start_op(DW'(8369910), BW'(678));
    lat = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0) busy_rdy++;
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 42) begin
      n_fail++;
      $display("FAIL basic_latency got %0d exp 42", lat);
    end
    n_tests++;
    if (busy_rdy != 0) begin
      n_fail++;
      $display("FAIL basic_in_ready_calc got %0d cycles with in_ready=1 exp 0", busy_rdy);
    end
    n_tests++;
    if ({quot, rem, err} !== {AW'(12345), BW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result got q=%0d r=%0d e=%b exp q=12345 r=0 e=0", quot, rem, err);
    end
    finish_op();
  endtask

  task automatic test_full_range();
    logic [BW-1:0] bmax;
    logic [DW-1:0] a;
    int lat;
    bmax = '1;
    a = DW'(QMAX) * DW'(bmax) + DW'(bmax) - DW'(1);
    start_op(a, bmax);
    wait_valid(lat);
    n_tests++;
    if ({quot, rem, err} !== {QMAX, bmax - BW'(1), 1'b0}) begin
      n_fail++;
      $display("FAIL full_range got q=%h r=%h e=%b exp q=%h r=%h e=0", quot, rem, err, QMAX, bmax - BW'(1));
    end
    finish_op();
  endtask

  task automatic test_div_zero();
    logic [DW-1:0] a;
    logic [BW-1:0] b;
    int lat;
    gen_ops(a, b);
    start_op(a, BW'(0));
    wait_valid(lat);
    n_tests++;
    if (lat != 0) begin
      n_fail++;
      $display("FAIL divzero_latency got %0d extra cycles exp 0 (valid right after accept)", lat);
    end
    n_tests++;
    if ({quot, rem, err} !== {QMAX, BW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL divzero_result got q=%h r=%h e=%b exp q=%h r=0 e=1", quot, rem, err, QMAX);
    end
    finish_op();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(DW'(1) << AW, BW'(1));
    wait_valid(lat);
    n_tests++;
    if ({lat, quot, rem, err} !== {32'(0), QMAX, BW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_err got lat=%0d q=%h r=%h e=%b exp lat=0 q=%h r=0 e=1", lat, quot, rem, err, QMAX);
    end
    finish_op();
    start_op((DW'(1) << AW) - DW'(1), BW'(1));
    wait_valid(lat);
    n_tests++;
    if ({lat, quot, rem, err} !== {32'(42), QMAX, BW'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL overflow_edge got lat=%0d q=%h r=%h e=%b exp lat=42 q=%h r=0 e=0", lat, quot, rem, err, QMAX);
    end
    finish_op();
  endtask

  task automatic test_stall();
    logic [DW-1:0] a;
    logic [BW-1:0] b, er;
    logic [AW-1:0] eq;
    logic          ee;
    int lat, moved;
    gen_ops(a, b);
    a = {BW'(a[DW-1:AW] % BW'(1000)), a[AW-1:0]};
    b = b | BW'(1000);
    ref_div(a, b, eq, er, ee);
    start_op(a, b);
    lat = 0;
    moved = 0;
    repeat (10) begin tick(); lat++; end
    ena = 1'b0;
    repeat (5) begin
      tick();
      lat++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) moved++;
    end
    ena = 1'b1;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    n_tests++;
    if (lat != 47 || moved != 0) begin
      n_fail++;
      $display("FAIL stall_latency got lat=%0d frozen_violations=%0d exp lat=47 violations=0", lat, moved);
    end
    n_tests++;
    if ({quot, rem, err} !== {eq, er, ee}) begin
      n_fail++;
      $display("FAIL stall_result got q=%h r=%h e=%b exp q=%h r=%h e=%b", quot, rem, err, eq, er, ee);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a;
    logic [BW-1:0] b, er;
    logic [AW-1:0] eq;
    logic          ee;
    int lat, unstable;
    gen_ops(a, b);
    ref_div(a, b, eq, er, ee);
    start_op(a, b);
    wait_valid(lat);
    unstable = 0;
    repeat (10) begin
      tick();
      if ({out_valid, in_ready, quot, rem, err} !== {1'b1, 1'b0, eq, er, ee}) unstable++;
    end
    n_tests++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold got %0d unstable cycles exp 0 (q=%h r=%h e=%b)", unstable, quot, rem, err);
    end
    ena = 1'b0;
    out_ready = 1'b1;
    tick();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL backpressure_ena_low got vld=%b rdy=%b exp vld=1 rdy=0", out_valid, in_ready);
    end
    ena = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] a;
    logic [BW-1:0] b;
    int lat;
    gen_ops(a, b);
    start_op(a, b | BW'(1));
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, err, quot, rem} !== {1'b1, 1'b0, 1'b0, AW'(0), BW'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid_state got rdy=%b vld=%b err=%b q=%h r=%h exp rdy=1 vld=0 err=0 q=0 r=0",
               in_ready, out_valid, err, quot, rem);
    end
    #1;
    rst_n = 1'b1;
    tick();
    start_op(DW'(100), BW'(7));
    wait_valid(lat);
    n_tests++;
    if ({lat, quot, rem, err} !== {32'(42), AW'(14), BW'(2), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_next got lat=%0d q=%0d r=%0d e=%b exp lat=42 q=14 r=2 e=0", lat, quot, rem, err);
    end
    finish_op();
  endtask

  task automatic test_random();
    exp_t          ex;
    logic [DW-1:0] a;
    logic [BW-1:0] b;
    logic [DW:0]   recon;
    int            done_ops, cyc, errs_seen;
    done_ops = 0;
    cyc = 0;
    errs_seen = 0;
    while (done_ops < N_RAND && cyc < 60000) begin
      ena       = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      gen_ops(a, b);
      dividend = a;
      divisor  = b;
      if (ena && out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious got out_valid=1 exp no pending operation");
        end else begin
          ex = sb.pop_front();
          if ({quot, rem, err} !== {ex.q, ex.r, ex.e}) begin
            n_fail++;
            $display("FAIL rand_result a=%h b=%h got q=%h r=%h e=%b exp q=%h r=%h e=%b",
                     ex.a, ex.b, quot, rem, err, ex.q, ex.r, ex.e);
          end
          if (ex.e) errs_seen++;
          else begin
            recon = (DW+1)'(quot) * (DW+1)'(ex.b) + (DW+1)'(rem);
            n_tests++;
            if (recon !== (DW+1)'(ex.a) || rem >= ex.b) begin
              n_fail++;
              $display("FAIL rand_identity a=%h b=%h got q*b+r=%h r=%h exp q*b+r=%h r<b",
                       ex.a, ex.b, recon, rem, ex.a);
            end
          end
        end
        done_ops++;
      end
      if (ena && in_valid && in_ready) begin
        ex.a = a;
        ex.b = b;
        ref_div(a, b, ex.q, ex.r, ex.e);
        sb.push_back(ex);
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (done_ops != N_RAND) begin
      n_fail++;
      $display("FAIL rand_timeout got %0d completed ops exp %0d", done_ops, N_RAND);
    end
    ena = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("[TB] random phase: %0d ops, %0d error results", done_ops, errs_seen);
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_full_range();
    test_div_zero();
    test_overflow();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
